// File: rtl/nn_accel_pkg.sv
// Shared definitions for the accelerator datapath: sequencer state encoding,
// memory geometry defaults and the address-width helper.
package nn_accel_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } wfs_state_t;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int NUM_DATA_DEF   = 4;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/weight_fetch_sequencer.sv
// Streams num_rows consecutive NUM_DATA-word windows from the parameter memory
// into a valid/ready output stage. Optional stall counter: WFS_STALL_CNT_EN.
module weight_fetch_sequencer
   import nn_accel_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 64,
   parameter int NUM_DATA   = NUM_DATA_DEF,
   parameter int ROW_CNT_W  = 8,
   localparam int AW        = addr_w(DEPTH)
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [AW-1:0]                        base_addr,
   input  logic [ROW_CNT_W-1:0]                 num_rows,
   output logic                                 busy,
   output logic                                 done,
   output logic [AW-1:0]                        mem_addr,
   input  logic [0:NUM_DATA-1][DATA_WIDTH-1:0]  mem_data,
   output logic [0:NUM_DATA-1][DATA_WIDTH-1:0]  out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_last,
   output logic [ROW_CNT_W-1:0]                 row_idx
`ifdef WFS_STALL_CNT_EN
   ,
   output logic [15:0]                          stall_cycles
`endif
);

   localparam logic [AW-1:0]        ADDR_STEP = AW'(NUM_DATA);
   localparam logic [ROW_CNT_W-1:0] ROW_ONE   = ROW_CNT_W'(1);

   wfs_state_t                           r_state;
   wfs_state_t                           w_next_state;
   logic [AW-1:0]                        r_mem_addr;
   logic [ROW_CNT_W-1:0]                 r_issued;
   logic [ROW_CNT_W-1:0]                 r_rows;
   logic [0:NUM_DATA-1][DATA_WIDTH-1:0]  r_out_data;
   logic                                 r_out_valid;
   logic                                 r_out_last;
   logic [ROW_CNT_W-1:0]                 r_row_idx;
   logic                                 r_done;

   logic w_start_run;
   logic w_start_zero;
   logic w_load;
   logic w_drain;
   logic w_final;

   always_comb begin
      w_next_state = r_state;
      w_start_run  = 1'b0;
      w_start_zero = 1'b0;
      w_load       = 1'b0;
      w_drain      = 1'b0;
      w_final      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (num_rows != '0) begin
                  w_start_run  = 1'b1;
                  w_next_state = RUN;
               end else begin
                  w_start_zero = 1'b1;
               end
            end
         end
         RUN: begin
            w_load  = (!r_out_valid || out_ready) && (r_issued < r_rows);
            w_drain = r_out_valid && out_ready && (r_issued == r_rows);
            w_final = r_out_valid && out_ready && r_out_last;
            if (w_final) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_addr  <= '0;
         r_issued    <= '0;
         r_rows      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_row_idx   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_start_zero || w_final;
         if (w_start_run) begin
            r_mem_addr <= base_addr;
            r_issued   <= '0;
            r_rows     <= num_rows;
         end
         // A load and the drain of the last window are mutually exclusive.
         if (w_load) begin
            r_out_data  <= mem_data;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_issued == r_rows - ROW_ONE);
            r_row_idx   <= r_issued;
            r_issued    <= r_issued + ROW_ONE;
            r_mem_addr  <= r_mem_addr + ADDR_STEP;
         end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

`ifdef WFS_STALL_CNT_EN
   logic [15:0] r_stall_cycles;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cycles <= '0;
      end else if (w_start_run) begin
         r_stall_cycles <= '0;
      end else if (r_state == RUN && r_out_valid && !out_ready && r_stall_cycles != '1) begin
         r_stall_cycles <= r_stall_cycles + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign mem_addr  = r_mem_addr;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign row_idx   = r_row_idx;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Self-checking bench for weight_fetch_sequencer against a window-list model
// of the memory contents; stall counter checks need WFS_STALL_CNT_EN.
module tb_weight_fetch_sequencer;

   localparam int DW    = 8;
   localparam int DEPTH = 64;
   localparam int ND    = 4;
   localparam int RW    = 8;
   localparam int AW    = 6;
   localparam int MAXC  = 300;

   typedef logic [0:ND-1][DW-1:0] win_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [RW-1:0] num_rows;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   win_t          mem_data;
   win_t          out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [RW-1:0] row_idx;
`ifdef WFS_STALL_CNT_EN
   logic [15:0]   stall_cycles;
`endif

   always #5 clk = ~clk;

   weight_fetch_sequencer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .NUM_DATA   (ND),
      .ROW_CNT_W  (RW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .num_rows     (num_rows),
      .busy         (busy),
      .done         (done),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .row_idx      (row_idx)
`ifdef WFS_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   // Parameter memory model: window read is combinational from mem_addr.
   logic [DW-1:0] mem [DEPTH];
   always_comb begin
      for (int i = 0; i < ND; i++) begin
         mem_data[i] = mem[(int'(mem_addr) + i) % DEPTH];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   win_t          t_data  [MAXC];
   logic          t_valid [MAXC];
   logic          t_ready [MAXC];
   logic          t_last  [MAXC];
   logic          t_busy  [MAXC];
   logic          t_done  [MAXC];
   logic [AW-1:0] t_addr  [MAXC];
   logic [RW-1:0] t_row   [MAXC];
   int            t_len;

   function automatic win_t exp_win(input int base, input int r);
      win_t w;
      for (int i = 0; i < ND; i++) begin
         w[i] = mem[(base + r * ND + i) % DEPTH];
      end
      return w;
   endfunction

   // Runs one start; records one trace entry per cycle (index 0 = cycle after the start edge).
   // mode: 0 always ready, 1 ready low for 3 cycles on row 1, 2 random ready.
   task automatic run(input int base, input int n, input int mode, input int inj_cyc,
                      input int linger, input int max_cyc);
      int  stall = 0;
      int  cyc   = 0;
      int  after = 0;
      bit  seen  = 0;
      if (base + n * ND > DEPTH) begin
         $display("FAIL range: base=%0d rows=%0d exceeds depth %0d", base, n, DEPTH);
         $fatal(1);
      end
      start     = 1'b1;
      base_addr = AW'(base);
      num_rows  = RW'(n);
      out_ready = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = AW'($urandom);
      num_rows  = RW'($urandom);
      forever begin
         case (mode)
            1: begin
               if (out_valid && row_idx == 1 && stall < 3) begin
                  out_ready = 1'b0;
                  stall++;
               end else begin
                  out_ready = 1'b1;
               end
            end
            2:       out_ready = ($urandom % 3) != 0;
            default: out_ready = 1'b1;
         endcase
         start = (cyc == inj_cyc);
         if (start) base_addr = '0;
         @(negedge clk);
         t_data[cyc]  = out_data;
         t_valid[cyc] = out_valid;
         t_ready[cyc] = out_ready;
         t_last[cyc]  = out_last;
         t_busy[cyc]  = busy;
         t_done[cyc]  = done;
         t_addr[cyc]  = mem_addr;
         t_row[cyc]   = row_idx;
         if (done) seen = 1;
         @(posedge clk); #1;
         cyc++;
         if (seen) after++;
         if (after >= linger || cyc >= max_cyc) break;
      end
      t_len     = cyc;
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b0;
      #1;
      n_tests++;
      if ({busy, done, out_valid, out_last, mem_addr, row_idx, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_async: busy=%b done=%b valid=%b last=%b addr=%0d row=%0d data=%h, want all 0",
                  busy, done, out_valid, out_last, mem_addr, row_idx, out_data);
      end
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, out_valid, out_last, mem_addr, row_idx, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_held: busy=%b done=%b valid=%b addr=%0d data=%h, want all 0",
                  busy, done, out_valid, mem_addr, out_data);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int k = 0;
      int ndone = 0;
      run(4, 3, 0, -1, 2, 60);
      for (int c = 0; c < t_len; c++) begin
         if (t_done[c]) begin
            ndone++;
            n_tests++;
            if (c != 4 || t_busy[c] !== 1'b0) begin
               n_fail++;
               $display("FAIL basic_done: done at cycle %0d busy=%b, want cycle 4 busy=0", c, t_busy[c]);
            end
         end
         if (t_valid[c] && t_ready[c]) begin
            n_tests++;
            if (c != k + 1 || t_row[c] !== RW'(k) || t_last[c] !== (k == 2) || t_data[c] !== exp_win(4, k)) begin
               n_fail++;
               $display("FAIL basic_window: cyc=%0d idx=%0d last=%b data=%h, want cyc=%0d idx=%0d last=%b data=%h",
                        c, t_row[c], t_last[c], t_data[c], k + 1, k, (k == 2), exp_win(4, k));
            end
            k++;
         end
      end
      n_tests++;
      if (k != 3 || ndone != 1) begin
         n_fail++;
         $display("FAIL basic_count: windows=%0d dones=%0d, want 3 and 1", k, ndone);
      end
      n_tests++;
      if (t_addr[t_len-1] !== AW'(16)) begin
         n_fail++;
         $display("FAIL basic_final_addr: got %0d, want 16", t_addr[t_len-1]);
      end
   endtask

   task automatic test_backpressure;
      int k = 0;
      int nstall = 0;
      run(4, 3, 1, -1, 2, 60);
      for (int c = 0; c < t_len; c++) begin
         if (t_valid[c] && !t_ready[c]) begin
            nstall++;
            n_tests++;
            if (t_row[c] !== RW'(1) || t_data[c] !== exp_win(4, 1) || t_addr[c] !== AW'(4 + 2 * ND) || t_last[c] !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_hold: cyc=%0d idx=%0d data=%h addr=%0d last=%b, want idx=1 data=%h addr=%0d last=0",
                        c, t_row[c], t_data[c], t_addr[c], t_last[c], exp_win(4, 1), 4 + 2 * ND);
            end
         end
         if (t_valid[c] && t_ready[c]) begin
            n_tests++;
            if (t_row[c] !== RW'(k) || t_last[c] !== (k == 2) || t_data[c] !== exp_win(4, k)) begin
               n_fail++;
               $display("FAIL bp_window: idx=%0d last=%b data=%h, want idx=%0d last=%b data=%h",
                        t_row[c], t_last[c], t_data[c], k, (k == 2), exp_win(4, k));
            end
            k++;
         end
      end
      n_tests++;
      if (k != 3 || nstall != 3) begin
         n_fail++;
         $display("FAIL bp_count: windows=%0d stalls=%0d, want 3 and 3", k, nstall);
      end
`ifdef WFS_STALL_CNT_EN
      n_tests++;
      if (stall_cycles !== 16'd3) begin
         n_fail++;
         $display("FAIL bp_stall_cycles: got %0d, want 3", stall_cycles);
      end
`endif
   endtask

   task automatic test_zero_rows;
      int ndone = 0;
      int nvb   = 0;
      run(8, 0, 0, -1, 3, 10);
      for (int c = 0; c < t_len; c++) begin
         if (t_done[c]) ndone++;
         if (t_valid[c] || t_busy[c]) nvb++;
      end
      n_tests++;
      if (t_done[0] !== 1'b1 || ndone != 1) begin
         n_fail++;
         $display("FAIL zero_done: done[0]=%b pulses=%0d, want 1 and 1", t_done[0], ndone);
      end
      n_tests++;
      if (nvb != 0) begin
         n_fail++;
         $display("FAIL zero_quiet: %0d cycles with valid or busy, want 0", nvb);
      end
   endtask

   task automatic test_ignored_start;
      int k = 0;
      int ndone = 0;
      run(4, 3, 0, 2, 3, 60);
      for (int c = 0; c < t_len; c++) begin
         if (t_done[c]) ndone++;
         if (t_valid[c] && t_ready[c]) begin
            n_tests++;
            if (t_row[c] !== RW'(k) || t_last[c] !== (k == 2) || t_data[c] !== exp_win(4, k)) begin
               n_fail++;
               $display("FAIL ign_window: idx=%0d last=%b data=%h, want idx=%0d last=%b data=%h",
                        t_row[c], t_last[c], t_data[c], k, (k == 2), exp_win(4, k));
            end
            k++;
         end
      end
      n_tests++;
      if (k != 3 || ndone != 1 || t_busy[t_len-1] !== 1'b0 || t_addr[t_len-1] !== AW'(16)) begin
         n_fail++;
         $display("FAIL ign_summary: windows=%0d dones=%0d busy=%b addr=%0d, want 3 1 0 16",
                  k, ndone, t_busy[t_len-1], t_addr[t_len-1]);
      end
   endtask

   task automatic test_reset_mid_run;
      int k = 0;
      int w = 0;
      int ndone = 0;
      start = 1'b1; base_addr = AW'(4); num_rows = RW'(3); out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      while (!(out_valid && row_idx == 1) && w < 20) begin
         out_ready = out_valid && row_idx == 0;
         @(posedge clk); #1;
         w++;
      end
      n_tests++;
      if (w >= 20) begin
         n_fail++;
         $display("FAIL rst_reach_row1: row 1 never valid, waited %0d cycles", w);
      end
      #1 rst = 1'b1;
      #1;
      n_tests++;
      if ({busy, done, out_valid, out_last, mem_addr, row_idx, out_data} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_async: busy=%b done=%b valid=%b last=%b addr=%0d row=%0d data=%h, want all 0",
                  busy, done, out_valid, out_last, mem_addr, row_idx, out_data);
      end
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      n_tests++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL rst_no_done: %0d cycles with done or busy after reset, want 0", ndone);
      end
      @(posedge clk); #1;
      run(20, 2, 0, -1, 2, 40);
      for (int c = 0; c < t_len; c++) begin
         if (t_valid[c] && t_ready[c]) begin
            n_tests++;
            if (t_row[c] !== RW'(k) || t_last[c] !== (k == 1) || t_data[c] !== exp_win(20, k)) begin
               n_fail++;
               $display("FAIL rst_fresh_window: idx=%0d last=%b data=%h, want idx=%0d last=%b data=%h",
                        t_row[c], t_last[c], t_data[c], k, (k == 1), exp_win(20, k));
            end
            k++;
         end
      end
      n_tests++;
      if (k != 2) begin
         n_fail++;
         $display("FAIL rst_fresh_count: windows=%0d, want 2", k);
      end
   endtask

   task automatic test_back_to_back;
      run(8, 2, 0, -1, 1, 40);
      run(0, 1, 0, -1, 2, 40);
      n_tests++;
      if (t_valid[0] !== 1'b0 || t_valid[1] !== 1'b1 || t_data[1] !== exp_win(0, 0) ||
          t_last[1] !== 1'b1 || t_row[1] !== RW'(0)) begin
         n_fail++;
         $display("FAIL b2b_window: v0=%b v1=%b data=%h last=%b idx=%0d, want 0 1 %h 1 0",
                  t_valid[0], t_valid[1], t_data[1], t_last[1], t_row[1], exp_win(0, 0));
      end
      n_tests++;
      if (t_done[2] !== 1'b1 || t_busy[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done: done[2]=%b busy[2]=%b, want 1 0", t_done[2], t_busy[2]);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      for (int r = 0; r < 8; r++) begin
         int base = ND * int'($urandom_range(0, DEPTH / ND - 1));
         int n    = int'($urandom_range(1, (DEPTH - base) / ND));
         int k    = 0;
         int ndone = 0;
         run(base, n, 2, -1, 2, 200);
         for (int c = 0; c < t_len; c++) begin
            if (t_done[c]) ndone++;
            if (t_valid[c] && t_ready[c]) begin
               n_tests++;
               if (t_row[c] !== RW'(k) || t_last[c] !== (k == n - 1) || t_data[c] !== exp_win(base, k)) begin
                  n_fail++;
                  $display("FAIL rand_window: run=%0d idx=%0d last=%b data=%h, want idx=%0d last=%b data=%h",
                           r, t_row[c], t_last[c], t_data[c], k, (k == n - 1), exp_win(base, k));
               end
               k++;
            end
         end
         n_tests++;
         if (k != n || ndone != 1 || t_addr[t_len-1] !== AW'((base + n * ND) % DEPTH)) begin
            n_fail++;
            $display("FAIL rand_summary: run=%0d windows=%0d dones=%0d addr=%0d, want %0d 1 %0d",
                     r, k, ndone, t_addr[t_len-1], n, (base + n * ND) % DEPTH);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_rows();
      test_ignored_start();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
